// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared response codes, payload type and status helper
package handshake_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int SEQ_W_DEFAULT = 8;

    typedef struct packed {
        logic [SEQ_W_DEFAULT-1:0] seq;
        logic [1:0]               resp;
    } resp_payload_t;

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } q_state_t;

    function automatic logic [1:0] resp_status(input logic [31:0] data,
                                               input logic [31:0] pattern);
        return (data == pattern) ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - response queue with EMPTY/PARTIAL/FULL occupancy state
module resp_fifo
    import handshake_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    q_state_t         state;
    q_state_t         state_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= Q_EMPTY;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    always_comb begin
        count_nxt = count;
        state_nxt = state;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        if (count_nxt == '0) begin
            state_nxt = Q_EMPTY;
        end else if (count_nxt == FULL_CNT) begin
            state_nxt = Q_FULL;
        end else begin
            state_nxt = Q_PARTIAL;
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (state == Q_EMPTY);
    assign full  = (state == Q_FULL);

endmodule

// File: rtl/handshake_resp_slave.sv
// rtl/handshake_resp_slave.sv - accepts request beats and returns one seq/status response per beat
module handshake_resp_slave
    import handshake_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          SEQ_W       = 8,
    parameter logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [SEQ_W-1:0] r_seq,
    output logic [1:0]       r_resp
);

    localparam int PW = SEQ_W + 2;

    logic             rst_done;
    logic [SEQ_W-1:0] seq_cnt;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic [PW-1:0]    wdata;
    logic [PW-1:0]    rdata;
    logic [PW-1:0]    last_head;

    assign ready = rst_done && !full;
    assign push  = valid && ready;
    assign pop   = r_valid && r_ready;
    assign wdata = {seq_cnt, resp_status(data_in, ERR_PATTERN)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done  <= 1'b0;
            seq_cnt   <= '0;
            data_out  <= '0;
            last_head <= '0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                data_out <= data_in;
                seq_cnt  <= seq_cnt + 1'b1;
            end
            if (pop) begin
                last_head <= rdata;
            end
        end
    end

    resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    // An empty queue's head slot is stale, so show the last popped entry instead.
    assign r_valid         = !empty;
    assign {r_seq, r_resp} = empty ? last_head : rdata;

endmodule

// File: tb/tb_handshake_resp_slave.sv
// tb/tb_handshake_resp_slave.sv - scoreboard bench for handshake_resp_slave
module tb_handshake_resp_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [7:0]  r_seq;
    logic [1:0]  r_resp;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [9:0]  sb[$];
    logic [9:0]  sb_e;
    logic [7:0]  exp_seq = '0;

    handshake_resp_slave #(
        .DEPTH       (4),
        .SEQ_W       (8),
        .ERR_PATTERN (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .ready    (ready),
        .data_in  (data_in),
        .data_out (data_out),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_seq    (r_seq),
        .r_resp   (r_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (r_valid && r_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    sb_e = sb.pop_front();
                    check("resp_seq", {24'd0, r_seq}, {24'd0, sb_e[9:2]});
                    check("resp_status", {30'd0, r_resp}, {30'd0, sb_e[1:0]});
                end
            end
            if (valid && ready) begin
                sb.push_back({exp_seq, (data_in == 32'hDEAD_BEEF) ? 2'b10 : 2'b00});
                exp_seq = exp_seq + 8'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_r_seq", {24'd0, r_seq}, 32'd0);
        sb.delete();
        exp_seq = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int   acc;
        int   drops;
        int   gaps;
        logic [7:0] k;

        // Reset release with a beat already pending
        valid   = 1'b1;
        data_in = 32'h1;
        #12;
        rst_n = 1'b1;
        #1;
        check("ready_first_cycle", {31'd0, ready}, 32'd0);
        tick();
        check("ready_after_rst_done", {31'd0, ready}, 32'd1);
        tick();
        valid = 1'b0;
        check("first_data_out", data_out, 32'h1);
        check("first_r_valid", {31'd0, r_valid}, 32'd1);
        check("first_r_seq", {24'd0, r_seq}, 32'd0);
        check("first_r_resp", {30'd0, r_resp}, 32'd0);

        // Fill to DEPTH with responses stalled, then free one slot
        do_reset();
        valid   = 1'b1;
        data_in = 32'h100;
        acc     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) acc++;
            @(posedge clk);
            #1;
            data_in = 32'h100 + acc;
        end
        check("full_accept_count", acc, 32'd4);
        check("full_ready_low", {31'd0, ready}, 32'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("ready_after_pop", {31'd0, ready}, 32'd1);
        tick();
        valid = 1'b0;
        check("fifth_beat_data", data_out, 32'h104);
        check("full_again", {31'd0, ready}, 32'd0);
        r_ready = 1'b1;
        repeat (5) tick();
        r_ready = 1'b0;
        check("drained_r_valid", {31'd0, r_valid}, 32'd0);

        // Error pattern followed by an ordinary word
        valid   = 1'b1;
        data_in = 32'hDEAD_BEEF;
        tick();
        data_in = 32'h0;
        tick();
        valid = 1'b0;
        check("slverr_head", {30'd0, r_resp}, 32'd2);
        check("data_out_zero", data_out, 32'h0);
        r_ready = 1'b1;
        tick();
        check("okay_after_slverr", {30'd0, r_resp}, 32'd0);
        tick();
        r_ready = 1'b0;
        check("err_drained", {31'd0, r_valid}, 32'd0);

        // Push and pop on the same edge at count 2
        k       = exp_seq;
        valid   = 1'b1;
        data_in = 32'h5;
        tick();
        data_in = 32'h6;
        tick();
        data_in = 32'h7;
        r_ready = 1'b1;
        tick();
        valid = 1'b0;
        check("pushpop_seq_adv", {24'd0, r_seq}, {24'd0, k + 8'd1});
        tick();
        check("pushpop_count_one_left", {31'd0, r_valid}, 32'd1);
        tick();
        check("pushpop_count_empty", {31'd0, r_valid}, 32'd0);
        r_ready = 1'b0;

        // 300 beats streaming with responses always taken
        do_reset();
        r_ready = 1'b1;
        valid   = 1'b1;
        drops   = 0;
        gaps    = 0;
        for (int i = 0; i < 300; i++) begin
            data_in = 32'h1000 + i;
            @(negedge clk);
            if (!ready) drops++;
            if (i > 0 && !r_valid) gaps++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        tick();
        r_ready = 1'b0;
        check("stream_ready_drops", drops, 32'd0);
        check("stream_latency_gaps", gaps, 32'd0);
        check("stream_drained", {31'd0, r_valid}, 32'd0);

        // Reset with responses queued
        valid = 1'b1;
        data_in = 32'h20;
        repeat (3) tick();
        valid = 1'b0;
        check("three_queued", {31'd0, r_valid}, 32'd1);
        do_reset();
        valid   = 1'b1;
        data_in = 32'h9;
        tick();
        tick();
        valid = 1'b0;
        check("post_reset_r_valid", {31'd0, r_valid}, 32'd1);
        check("post_reset_r_seq", {24'd0, r_seq}, 32'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("post_reset_drained", {31'd0, r_valid}, 32'd0);
        check("sb_empty_at_end", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/handshake_resp_slave.md
# handshake_resp_slave

Slave-side responder for the valid/ready handshake channel. It accepts 32-bit data beats from a `handshake_master` and latches each accepted word on `data_out`. For every accepted beat it returns a response beat (sequence number plus status) to the master on a reverse valid/ready channel. It sits at the downstream end of the master→slave link and closes the loop so the master can confirm delivery per beat.

## Interface
Parameters:
- `DEPTH`, 4: response queue entries; power of two, ≥ 2.
- `SEQ_W`, 8: sequence-number width.
- `ERR_PATTERN`, 32'hDEAD_BEEF: data word that is answered with `SLVERR`.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `valid` input 1: request beat valid, driven by the master.
- `ready` output 1: request beat ready, driven to the master.
- `data_in` input 32: request payload.
- `data_out` output 32: last accepted request word.
- `r_valid` output 1: response beat valid.
- `r_ready` input 1: master is ready to take the response.
- `r_seq` output SEQ_W: sequence number of the response.
- `r_resp` output 2: response status, `OKAY` or `SLVERR`.

## Operation
- Reset values: `ready`=0, `data_out`=0, `r_valid`=0, `r_seq`=0, `r_resp`=0. Internal state is also cleared: `seq_cnt`=0, queue empty, `rst_done`=0.
- `rst_done` is a flop that sets on the first `clk` edge after `rst_n` deasserts.
- `ready` = `rst_done` && (queue count < DEPTH). It is a function of registered state only; there is no combinational path from `r_ready` or `valid`.
- A request is accepted when `valid && ready` at a rising edge. On acceptance:
  - `data_out` <= `data_in`.
  - Push {`seq_cnt`, status} into the queue.
  - `seq_cnt` <= `seq_cnt` + 1, mod 2^SEQ_W; 255 wraps to 0 when SEQ_W=8.
- Status is `SLVERR` (2'b10) when `data_in` == ERR_PATTERN; otherwise it is `OKAY` (2'b00).
- `r_valid` = queue not empty. `r_seq` and `r_resp` always present the queue head.
- A response completes when `r_valid && r_ready` at a rising edge; the head is popped on that edge.
- Once `r_valid` rises, it and `r_seq`/`r_resp` must hold stable until the response handshake completes.
- While the queue is empty, `r_seq`/`r_resp` hold their last value.
- Queue count state machine:
  - EMPTY: count=0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count=DEPTH.
  - Push only: count +1. Pop only: count −1. Push and pop together, or neither: count unchanged.
- FULL: `ready`=0, so no push can occur. A pop on that edge returns the state to PARTIAL, and `ready` rises the next cycle.
- EMPTY: no pop can occur because `r_valid`=0. `r_ready` is ignored.
- Read and write pointers are log2(DEPTH) bits wide and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Queued responses are discarded and the sequence number restarts at 0.

## Timing
- Request acceptance costs zero extra cycles: back-to-back beats are accepted every cycle while `ready`=1.
- `data_out` updates on the accepting edge and is visible in the following cycle.
- Response latency: a beat accepted at edge N into an empty queue raises `r_valid` after edge N, i.e. visible in cycle N+1. There is no combinational path from `valid` to `r_valid`.
- Throughput: one response per cycle while `r_ready`=1.
- With `r_ready` held at 1 continuously, `ready` never drops after reset.
- First acceptance is possible at the second rising edge after `rst_n` deasserts.

## Structure
- Shared package `handshake_pkg` holds:
  - Response codes `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
  - A typedef for the response payload, {seq, resp}.
- Sub-module `resp_fifo` is a synchronous FIFO of width SEQ_W+2 and depth DEPTH.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `empty`, `full`.
  - Async active-low reset.
  - `rdata` is the head entry, read combinationally from the storage array.
- The top level holds `rst_done`, `seq_cnt`, the `data_out` register, status compare, and glue logic.

## Test plan
- Reset release with `valid`=1, `data_in`=32'h1 → `ready`=0 in the first cycle. Beat accepted at the second edge. `data_out`=32'h1. The next cycle shows `r_valid`=1, `r_seq`=0, `r_resp`=OKAY.
- `r_ready`=0 with 5 back-to-back beats at DEPTH=4 → 4 beats accepted, then `ready`=0. Raise `r_ready` for one cycle → `r_seq`=0 popped, `ready`=1 the next cycle, and the 5th beat is accepted with seq 4.
- `data_in`=32'hDEAD_BEEF → `r_resp`=2'b10. The following word 32'h0 gives `r_resp`=2'b00.
- Continuous `valid`=1 and `r_ready`=1 for 300 beats → `ready` never drops. `r_seq` runs 0…255, then 0…43; every response arrives one cycle after its beat.
- Queue at count 2 with push and pop on the same edge → count stays 2 and `r_seq` advances by 1.
- `rst_n` pulsed low with 3 queued responses → `r_valid`=0 and `ready`=0 immediately. After release, the first response carries `r_seq`=0.
